// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the multi-cycle RV32I core.
// Latency: 3 cycles per instruction (4 if it traps). Stalls in FETCH/HOLD/EXEC until ack/ready/resolve.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_instr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        resolve_valid,
  input  logic [1:0]  resolve_kind,
  input  logic        branch_taken,
  input  logic [31:0] rs1_val,
  input  logic [31:0] imm,
  output logic [31:0] link_pc,
  output logic        trap,
  output logic [31:0] trap_epc,
  output logic [31:0] instret
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  localparam logic [1:0] KIND_SEQ    = 2'b00;
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_JAL    = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] trap_epc_q, trap_epc_d;
  logic [31:0] instret_q, instret_d;

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;
  logic [31:0] target;
  logic        misaligned;

  assign seq_pc = pc_q + 32'd4;
  assign rel_pc = pc_q + imm;

  // Only the selected target is checked, so a not-taken branch never traps on pc+imm.
  always_comb begin
    case (resolve_kind)
      KIND_SEQ:    target = seq_pc;
      KIND_BRANCH: target = branch_taken ? rel_pc : seq_pc;
      KIND_JAL:    target = rel_pc;
      default:     target = (rs1_val + imm) & ~32'h1;
    endcase
  end

  assign misaligned = |target[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    trap_epc_d = trap_epc_q;
    instret_d  = instret_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_ack) begin
          instr_d    = fetch_instr;
          instr_pc_d = pc_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (resolve_valid) begin
          if (misaligned) begin
            state_d = ST_TRAP;
          end else begin
            pc_d      = target;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      default: begin
        // pc still holds the faulting instruction's address here.
        trap_epc_d = pc_q;
        pc_d       = TRAP_VEC;
        state_d    = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      trap_epc_q <= 32'h0;
      instret_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      trap_epc_q <= trap_epc_d;
      instret_q  <= instret_d;
    end
  end

  assign fetch_req   = (state_q == ST_FETCH) && !rst;
  assign fetch_addr  = pc_q;
  assign instr_valid = (state_q == ST_HOLD) && !rst;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign link_pc     = seq_pc;
  assign trap        = (state_q == ST_TRAP) && !rst;
  assign trap_epc    = trap_epc_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a per-instruction reference model.
module tb_pc_sequencer;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_instr = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        resolve_valid = 1'b0;
  logic [1:0]  resolve_kind = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] rs1_val = 32'h0;
  logic [31:0] imm = 32'h0;
  logic [31:0] link_pc;
  logic        trap;
  logic [31:0] trap_epc;
  logic [31:0] instret;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_instret = 32'h0;
  logic [31:0] m_epc     = 32'h0;

  pc_sequencer dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .resolve_valid(resolve_valid), .resolve_kind(resolve_kind),
    .branch_taken(branch_taken), .rs1_val(rs1_val), .imm(imm),
    .link_pc(link_pc), .trap(trap), .trap_epc(trap_epc), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [1:0] kind, input logic taken,
                                             input logic [31:0] pc, input logic [31:0] rs1,
                                             input logic [31:0] off);
    logic [31:0] t;
    if (kind == 2'b00)      t = pc + 4;
    else if (kind == 2'b01) t = taken ? pc + off : pc + 4;
    else if (kind == 2'b10) t = pc + off;
    else                    t = (rs1 + off) & 32'hFFFF_FFFE;
    return t;
  endfunction

  // Drive random values on inputs the DUT must ignore in the current phase.
  task automatic noise_exec_inputs();
    resolve_kind = 2'($urandom);
    branch_taken = 1'($urandom);
    rs1_val      = $urandom;
    imm          = $urandom;
  endtask

  // Runs one instruction through fetch/hold/exec; entered and left at a negedge in FETCH.
  task automatic run_instr(input int ack_dly, input int rdy_dly, input int res_dly,
                           input logic [1:0] kind, input logic taken,
                           input logic [31:0] rs1, input logic [31:0] off,
                           input logic [31:0] iw);
    logic [31:0] tgt;
    for (int i = 0; i <= ack_dly; i++) begin
      chk("fetch_req", {31'h0, fetch_req}, 32'h1);
      chk("fetch_addr", fetch_addr, m_pc);
      chk("fetch_valid_lo", {31'h0, instr_valid}, 32'h0);
      fetch_ack     = (i == ack_dly);
      fetch_instr   = (i == ack_dly) ? iw : $urandom;
      resolve_valid = 1'($urandom);
      instr_ready   = 1'($urandom);
      noise_exec_inputs();
      @(negedge clk);
    end
    fetch_ack = 1'b0;
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("hold_valid", {31'h0, instr_valid}, 32'h1);
      chk("hold_instr", instr, iw);
      chk("hold_instr_pc", instr_pc, m_pc);
      chk("hold_fetch_req", {31'h0, fetch_req}, 32'h0);
      instr_ready   = (i == rdy_dly);
      fetch_ack     = 1'($urandom);
      fetch_instr   = $urandom;
      resolve_valid = 1'($urandom);
      noise_exec_inputs();
      @(negedge clk);
    end
    instr_ready = 1'b0;
    for (int i = 0; i <= res_dly; i++) begin
      chk("exec_valid_lo", {31'h0, instr_valid}, 32'h0);
      chk("exec_link_pc", link_pc, m_pc + 32'd4);
      chk("exec_trap_lo", {31'h0, trap}, 32'h0);
      chk("exec_instr", instr, iw);
      fetch_ack     = 1'($urandom);
      fetch_instr   = $urandom;
      instr_ready   = 1'($urandom);
      resolve_valid = (i == res_dly);
      if (i == res_dly) begin
        resolve_kind = kind;
        branch_taken = taken;
        rs1_val      = rs1;
        imm          = off;
      end else begin
        noise_exec_inputs();
      end
      @(negedge clk);
    end
    resolve_valid = 1'b0;
    fetch_ack     = 1'b0;
    instr_ready   = 1'b0;
    tgt = ref_target(kind, taken, m_pc, rs1, off);
    if (tgt[1:0] != 2'b00) begin
      chk("trap_pulse", {31'h0, trap}, 32'h1);
      chk("trap_instret", instret, m_instret);
      @(negedge clk);
      m_epc = m_pc;
      m_pc  = TRAP_VEC;
    end else begin
      m_pc      = tgt;
      m_instret = m_instret + 32'd1;
    end
    chk("post_trap_lo", {31'h0, trap}, 32'h0);
    chk("post_fetch_addr", fetch_addr, m_pc);
    chk("post_instret", instret, m_instret);
    chk("post_trap_epc", trap_epc, m_epc);
  endtask

  initial begin
    logic [1:0]  kind;
    logic [31:0] off;
    logic [31:0] rs1;

    #2;
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_trap", {31'h0, trap}, 32'h0);
    chk("rst_instret", instret, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fetch_addr", fetch_addr, 32'h0);
    chk("rst_trap_epc", trap_epc, 32'h0);

    // Minimum-latency sequential instruction: exactly three cycles.
    run_instr(0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0013);
    chk("seq_instr_pc", instr_pc, 32'h0);
    chk("seq_fetch4", fetch_addr, 32'h4);

    // jal/branch from known pcs.
    run_instr(0, 0, 0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0000_0067);
    run_instr(0, 0, 0, 2'b10, 1'b0, 32'h0, 32'h20, 32'h0200_006F);
    chk("jal_fetch", fetch_addr, 32'h20);
    run_instr(1, 0, 0, 2'b01, 1'b1, 32'h0, 32'hFFFF_FFF8, 32'hFE00_0CE3);
    chk("br_taken_fetch", fetch_addr, 32'h18);
    run_instr(0, 0, 0, 2'b10, 1'b0, 32'h0, 32'h8, 32'h0080_006F);
    run_instr(0, 0, 0, 2'b01, 1'b0, 32'h0, 32'h0000_0002, 32'h0000_0063);
    chk("br_ntaken_fetch", fetch_addr, 32'h24);

    // Misaligned jalr traps; an odd base that clears to aligned does not.
    run_instr(0, 0, 0, 2'b11, 1'b0, 32'h103, 32'h0, 32'h0000_8067);
    chk("trap_vec_fetch", fetch_addr, 32'h10);
    chk("trap_epc_val", trap_epc, 32'h24);
    run_instr(0, 0, 0, 2'b11, 1'b0, 32'h101, 32'h0, 32'h0000_8067);
    chk("jalr_odd_fetch", fetch_addr, 32'h100);

    // Backpressure on every handshake.
    run_instr(3, 2, 2, 2'b00, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF);

    // pc and instret wrap.
    run_instr(0, 0, 0, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0000_8067);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    run_instr(0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0013);
    chk("wrap_pc", fetch_addr, 32'h0);
    chk("wrap_instret", instret, 32'h0);

    // Reset asserted while in EXEC.
    run_instr(0, 0, 0, 2'b10, 1'b0, 32'h0, 32'h40, 32'h0400_006F);
    fetch_ack   = 1'b1;
    @(negedge clk);
    fetch_ack   = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("pre_rst_link", link_pc, 32'h44);
    rst = 1'b1;
    #1;
    chk("rst_exec_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_exec_trap", {31'h0, trap}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("rel_fetch_addr", fetch_addr, 32'h0);
    chk("rel_instret", instret, 32'h0);
    chk("rel_instr", instr, 32'h0);
    m_pc = 32'h0; m_instret = 32'h0; m_epc = 32'h0;
    @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      kind = 2'($urandom);
      off  = ($urandom_range(0, 64) * 4) - 32'd128;
      if ($urandom_range(0, 7) == 0) off = off + 32'($urandom_range(1, 3));
      rs1  = $urandom;
      if ($urandom_range(0, 1) == 0) rs1[1:0] = 2'b00;
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                kind, 1'($urandom), rs1, off, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
